// File: rtl/uart_frame_rx.sv
// UART 8N1 frame receiver: assembles NBYTES data bytes plus CRC_L/CRC_H, checks CRC-16/MODBUS
// and publishes the data bus only on a good frame.
module uart_frame_rx #(
  parameter int unsigned NBYTES       = 16,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RXD,
  output logic [NBYTES*8-1:0] data,
  output logic                frame_valid,
  output logic                crc_err,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF    = CLKS_PER_BIT / 2;
  localparam int unsigned TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W    = $clog2(TO_CLKS);
  localparam int unsigned BC_W    = $clog2(NBYTES + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t            state, state_n;
  logic              rx_meta, rxs, rxs_prev;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [7:0]        rx_byte;
  logic              byte_done;
  logic              tick_c, bit_c, stop_ok_c, stop_bad_c;
  logic [TO_W-1:0]   to_cnt;
  logic              to_run_c, to_fire_c;
  logic [BC_W-1:0]   byte_cnt;
  logic [15:0]       crc;
  logic [2:0]        crc_steps;
  logic [7:0]        rx_crc_l;
  logic [7:0]        shadow [NBYTES];
  logic              pub_good, pub_bad;

  function automatic logic [15:0] crc_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  // RXD synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= RXD;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Bit-level FSM: start-bit qualification at half bit, then one sample per bit time
  always_comb begin
    state_n    = state;
    tick_c     = 1'b0;
    bit_c      = 1'b0;
    stop_ok_c  = 1'b0;
    stop_bad_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxs_prev && !rxs) state_n = S_START;
      end
      S_START: begin
        if (clk_cnt == CNT_W'(HALF - 1)) begin
          tick_c  = 1'b1;
          state_n = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          tick_c = 1'b1;
          bit_c  = 1'b1;
          if (bit_cnt == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          tick_c = 1'b1;
          if (rxs) begin
            stop_ok_c = 1'b1;
            state_n   = S_IDLE;
          end else begin
            stop_bad_c = 1'b1;
            state_n    = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= stop_ok_c;
      if (tick_c || state == S_IDLE || state == S_WAIT_HIGH) clk_cnt <= '0;
      else                                                   clk_cnt <= clk_cnt + CNT_W'(1);
      if (state == S_IDLE) bit_cnt <= '0;
      else if (bit_c) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= {rxs, rx_shift[7:1]};
      end
      if (stop_ok_c) rx_byte <= rx_shift;
    end
  end

  // Inter-byte timeout only runs while idle inside a partially received frame
  assign to_run_c  = (state == S_IDLE) && (byte_cnt != '0);
  assign to_fire_c = to_run_c && (to_cnt == TO_W'(TO_CLKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          to_cnt <= '0;
    else if (!to_run_c)  to_cnt <= '0;
    else if (to_fire_c)  to_cnt <= '0;
    else                 to_cnt <= to_cnt + TO_W'(1);
  end

  // Frame assembly one cycle after byte_done, publish one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      crc         <= 16'hFFFF;
      crc_steps   <= '0;
      rx_crc_l    <= '0;
      pub_good    <= 1'b0;
      pub_bad     <= 1'b0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      data        <= '0;
      for (int unsigned i = 0; i < NBYTES; i++) shadow[i] <= '0;
    end else begin
      pub_good    <= 1'b0;
      pub_bad     <= 1'b0;
      frame_err   <= 1'b0;
      frame_valid <= pub_good;
      crc_err     <= pub_bad;
      busy        <= (byte_cnt != '0) || (state != S_IDLE && state != S_WAIT_HIGH);
      if (pub_good) begin
        for (int unsigned i = 0; i < NBYTES; i++) data[i*8 +: 8] <= shadow[i];
      end
      if (stop_bad_c || to_fire_c) begin
        frame_err <= 1'b1;
        byte_cnt  <= '0;
        crc       <= 16'hFFFF;
        crc_steps <= '0;
      end else if (byte_done) begin
        if (byte_cnt < BC_W'(NBYTES)) begin
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (byte_cnt == BC_W'(i)) shadow[i] <= rx_byte;
          end
          crc       <= crc_step(crc ^ {8'h00, rx_byte});
          crc_steps <= 3'd7;
          byte_cnt  <= byte_cnt + BC_W'(1);
        end else if (byte_cnt == BC_W'(NBYTES)) begin
          rx_crc_l <= rx_byte;
          byte_cnt <= byte_cnt + BC_W'(1);
        end else begin
          pub_good <= ({rx_byte, rx_crc_l} == crc);
          pub_bad  <= ({rx_byte, rx_crc_l} != crc);
          byte_cnt <= '0;
          crc      <= 16'hFFFF;
        end
      end else if (crc_steps != '0) begin
        crc       <= crc_step(crc);
        crc_steps <= crc_steps - 3'd1;
      end
    end
  end

endmodule
